// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the byte-wide memory
// and the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16
) ();
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_flush;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [31:0]       ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_ack;
  logic [31:0]       ls_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  mem_rdata,
    output if_ack, if_rdata,
    output ls_ack, ls_rdata,
    output mem_addr, mem_wdata, mem_we,
    output busy
  );

  modport master (
    output if_req, if_addr, if_flush,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output mem_rdata,
    input  if_ack, if_rdata,
    input  ls_ack, ls_rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory between IF and LS; each word is
// four little-endian byte cycles, LS first with an IF anti-starve.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    IF_XFER,
    LS_XFER,
    ACK_IF,
    ACK_LS
  } state_t;

  localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [3:0]        r_starve;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [23:0]       r_stage;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_ls_rdata;
  logic              r_if_ack;
  logic              r_ls_ack;

  logic        w_xfer;
  logic        w_if_go;
  logic        w_ls_go;
  logic        w_store;
  logic [31:0] w_word;
  logic        w_unused;

  assign w_xfer  = (r_state == IF_XFER) ||
                   (r_state == LS_XFER);
  assign w_if_go = bus.if_req && !bus.if_flush;
  assign w_ls_go = bus.ls_req &&
                   ((r_starve < SLIM) ||
                    !bus.if_req || bus.if_flush);
  assign w_store = (r_state == LS_XFER) && r_we;
  // Staging shifts right, so byte 3 arrives straight off the bus.
  assign w_word  = {bus.mem_rdata, r_stage};

  assign w_unused = ^{bus.if_addr[31:ADDR_W],
                      bus.ls_addr[31:ADDR_W]};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= 2'd0;
      r_starve   <= 4'd0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= 32'h0;
      r_stage    <= 24'h0;
      r_if_rdata <= 32'h0;
      r_ls_rdata <= 32'h0;
      r_if_ack   <= 1'b0;
      r_ls_ack   <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_ls_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_ls_go) begin
            r_state  <= LS_XFER;
            r_addr   <= bus.ls_addr[ADDR_W-1:0];
            r_we     <= bus.ls_we;
            r_wdata  <= bus.ls_wdata;
            r_cnt    <= 2'd0;
            r_starve <= w_if_go ?
                        r_starve + 4'd1 : 4'd0;
          end else if (w_if_go) begin
            r_state  <= IF_XFER;
            r_addr   <= bus.if_addr[ADDR_W-1:0];
            r_cnt    <= 2'd0;
            r_starve <= 4'd0;
          end
        end
        IF_XFER: begin
          if (bus.if_flush) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
          end else begin
            r_stage <= {bus.mem_rdata, r_stage[23:8]};
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state    <= ACK_IF;
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_word;
            end
          end
        end
        LS_XFER: begin
          if (!r_we)
            r_stage <= {bus.mem_rdata, r_stage[23:8]};
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state  <= ACK_LS;
            r_ls_ack <= 1'b1;
            if (!r_we)
              r_ls_rdata <= w_word;
          end
        end
        ACK_IF, ACK_LS: begin
          r_state <= IDLE;
          r_cnt   <= 2'd0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = w_xfer ?
    r_addr + {{(ADDR_W-2){1'b0}}, r_cnt} : '0;
  assign bus.mem_we    = w_store;
  assign bus.mem_wdata = w_store ?
    r_wdata[{r_cnt, 3'b000} +: 8] : 8'h00;
  assign bus.if_ack    = r_if_ack;
  assign bus.ls_ack    = r_ls_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal
// expectations plus random traffic against a transaction model.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int SL = 2;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory image: unwritten bytes come from a fixed pattern
  logic [7:0] tmem [0:65535];
  bit         tv   [0:65535];
  logic [7:0] rmem [0:65535];
  bit         rv   [0:65535];

  function automatic logic [7:0] init_byte(logic [AW-1:0] a);
    logic [31:0] w3;
    w3 = 32'hCAFEF00D;
    if (a >= 16'h0100 && a <= 16'h0103)
      return 8'h13 - 8'(a - 16'h0100);
    if (a >= 16'h0300 && a <= 16'h0303)
      return w3[8*(a - 16'h0300) +: 8];
    if (a >= 16'h0400 && a <= 16'h0403)
      return 8'h00;
    return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] tb_byte(logic [AW-1:0] a);
    return tv[a] ? tmem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] rb(logic [AW-1:0] a);
    return rv[a] ? rmem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(logic [AW-1:0] a);
    return {rb(AW'(a + 3)), rb(AW'(a + 2)),
            rb(AW'(a + 1)), rb(a)};
  endfunction

  always_comb
    bus.mem_rdata = tv[bus.mem_addr] ? tmem[bus.mem_addr]
                                     : init_byte(bus.mem_addr);

  always @(posedge Clk)
    if (bus.mem_we) begin
      tmem[bus.mem_addr] <= bus.mem_wdata;
      tv[bus.mem_addr]   <= 1'b1;
    end

  // Transaction model: owner 0 none, 1 IF, 2 LS; phase 0..3 bytes, 4 ack
  int          m_own, m_ph, m_st;
  logic [AW-1:0] m_a;
  logic        m_we;
  logic [31:0] m_wd, m_word, m_ifr, m_lsr;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_own <= 0;
      m_ph  <= 0;
      m_st  <= 0;
      m_ifr <= 32'h0;
      m_lsr <= 32'h0;
    end else if (m_own == 0) begin
      if (bus.ls_req &&
          (m_st < SL || !bus.if_req || bus.if_flush)) begin
        m_own  <= 2;
        m_ph   <= 0;
        m_a    <= bus.ls_addr[AW-1:0];
        m_we   <= bus.ls_we;
        m_wd   <= bus.ls_wdata;
        m_word <= ref_word(bus.ls_addr[AW-1:0]);
        m_st   <= (bus.if_req && !bus.if_flush) ? m_st + 1 : 0;
      end else if (bus.if_req && !bus.if_flush) begin
        m_own  <= 1;
        m_ph   <= 0;
        m_a    <= bus.if_addr[AW-1:0];
        m_word <= ref_word(bus.if_addr[AW-1:0]);
        m_st   <= 0;
      end
    end else if (m_ph == 4) begin
      m_own <= 0;
    end else if (m_own == 1 && bus.if_flush) begin
      m_own <= 0;
    end else begin
      if (m_own == 2 && m_we) begin
        rmem[AW'(m_a + m_ph)] <= m_wd[8*m_ph +: 8];
        rv[AW'(m_a + m_ph)]   <= 1'b1;
      end
      if (m_ph == 3) begin
        if (m_own == 1) m_ifr <= m_word;
        else if (!m_we) m_lsr <= m_word;
      end
      m_ph <= m_ph + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic e_xfer();
    return m_own != 0 && m_ph < 4;
  endfunction

  function automatic logic e_we();
    return e_xfer() && m_own == 2 && m_we;
  endfunction

  always @(negedge Clk) begin
    chk("busy", 32'(bus.busy), 32'(m_own != 0));
    chk("mem_addr", 32'(bus.mem_addr),
        e_xfer() ? 32'(AW'(m_a + m_ph)) : 32'h0);
    chk("mem_we", 32'(bus.mem_we), 32'(e_we()));
    if (e_we() || !e_xfer())
      chk("mem_wdata", 32'(bus.mem_wdata),
          e_we() ? 32'(m_wd[8*m_ph +: 8]) : 32'h0);
    chk("if_ack", 32'(bus.if_ack), 32'(m_own == 1 && m_ph == 4));
    chk("ls_ack", 32'(bus.ls_ack), 32'(m_own == 2 && m_ph == 4));
    chk("if_rdata", bus.if_rdata, m_ifr);
    chk("ls_rdata", bus.ls_rdata, m_lsr);
  end

  function automatic logic [31:0] rnd_addr();
    logic [15:0] hi, lo;
    hi = $urandom_range(0, 1) ? 16'hABCD : 16'h0000;
    lo = ($urandom_range(0, 1) ? 16'hFFE0 : 16'h0100) +
         16'($urandom_range(0, 31));
    return {hi, lo};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    string s;
    int got;
    int bad;
    logic [15:0] w6 [4];
    w6 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.ls_req = 0; bus.ls_we = 0;
    bus.ls_addr = 0; bus.ls_wdata = 0;

    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_rd", bus.if_rdata | bus.ls_rdata, 0);
    #3 Reset_n = 1'b1;
    @(negedge Clk);

    bus.if_req = 1; bus.if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("t2_addr", 32'(bus.mem_addr), 32'h100 + k);
      chk("t2_busy", 32'(bus.busy), 1);
    end
    @(negedge Clk);
    chk("t2_ack", 32'(bus.if_ack), 1);
    chk("t2_rdata", bus.if_rdata, 32'h10111213);
    bus.if_req = 0;
    @(negedge Clk);
    chk("t2_idle", 32'(bus.busy), 0);

    bus.ls_req = 1; bus.ls_we = 1;
    bus.ls_addr = 32'h200; bus.ls_wdata = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("t3_we", 32'(bus.mem_we), 1);
      chk("t3_addr", 32'(bus.mem_addr), 32'h200 + k);
    end
    @(negedge Clk);
    chk("t3_ack", 32'(bus.ls_ack), 1);
    chk("t3_rd_hold", bus.ls_rdata, 0);
    bus.ls_req = 0;
    @(negedge Clk);
    chk("t3_mem", {tb_byte(16'h203), tb_byte(16'h202),
                   tb_byte(16'h201), tb_byte(16'h200)},
        32'hDEADBEEF);
    bus.ls_req = 1; bus.ls_we = 0;
    repeat (5) @(negedge Clk);
    chk("t3_lack", 32'(bus.ls_ack), 1);
    chk("t3_load", bus.ls_rdata, 32'hDEADBEEF);
    bus.ls_req = 0;
    @(negedge Clk);

    s = "";
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h200;
    for (int c = 0; c < 80 && s.len() < 6; c++) begin
      @(negedge Clk);
      if (bus.if_ack) s = {s, "I"};
      if (bus.ls_ack) s = {s, "L"};
    end
    bus.if_req = 0; bus.ls_req = 0;
    n_tests++;
    if (s != "LLILLI") begin
      n_fail++;
      $display("FAIL t4_order: got %s want LLILLI", s);
    end
    repeat (2) @(negedge Clk);

    bus.if_req = 1; bus.if_addr = 32'h100;
    repeat (3) @(negedge Clk);
    chk("t5_cnt2", 32'(bus.mem_addr), 32'h102);
    bus.if_flush = 1;
    @(negedge Clk);
    chk("t5_abort", 32'(bus.busy), 0);
    chk("t5_noack", 32'(bus.if_ack), 0);
    chk("t5_hold", bus.if_rdata, 32'h10111213);
    bus.if_flush = 0; bus.if_addr = 32'h300;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge Clk);
      if (bus.if_ack) got = 1;
    end
    chk("t5_ack", 32'(got), 1);
    chk("t5_rdata", bus.if_rdata, 32'hCAFEF00D);
    bus.if_req = 0;
    @(negedge Clk);

    bus.if_req = 1; bus.if_addr = 32'h0000FFFE;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("t6_wrap", 32'(bus.mem_addr), 32'(w6[k]));
    end
    @(negedge Clk);
    bus.if_req = 0;
    @(negedge Clk);

    bus.ls_req = 1; bus.ls_we = 1;
    bus.ls_addr = 32'h400; bus.ls_wdata = 32'h44332211;
    repeat (2) @(negedge Clk);
    chk("t7_cnt1", 32'(bus.mem_addr), 32'h401);
    #3 Reset_n = 1'b0;
    #1;
    chk("t7_busy", 32'(bus.busy), 0);
    chk("t7_we", 32'(bus.mem_we), 0);
    chk("t7_addr", 32'(bus.mem_addr), 0);
    chk("t7_wd", 32'(bus.mem_wdata), 0);
    chk("t7_rd", bus.if_rdata | bus.ls_rdata, 0);
    bus.ls_req = 0;
    repeat (2) @(negedge Clk);
    chk("t7_ack", 32'(bus.ls_ack), 0);
    chk("t7_mem", {tb_byte(16'h403), tb_byte(16'h402),
                   tb_byte(16'h401), tb_byte(16'h400)},
        32'h00000011);
    #3 Reset_n = 1'b1;
    @(negedge Clk);
    bus.if_req = 1; bus.if_addr = 32'h100;
    repeat (5) @(negedge Clk);
    chk("t7_ifack", 32'(bus.if_ack), 1);
    chk("t7_ifrd", bus.if_rdata, 32'h10111213);
    bus.if_req = 0;
    @(negedge Clk);

    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      bus.if_flush = 0;
      if (bus.if_ack || !bus.if_req) begin
        bus.if_req = ($urandom_range(0, 3) != 0);
        bus.if_addr = rnd_addr();
      end else if ($urandom_range(0, 15) == 0) begin
        bus.if_flush = 1;
        bus.if_addr = rnd_addr();
      end
      if (bus.ls_ack || !bus.ls_req) begin
        bus.ls_req = ($urandom_range(0, 2) != 0);
        bus.ls_we = 1'($urandom_range(0, 1));
        bus.ls_addr = rnd_addr();
        bus.ls_wdata = $urandom;
      end
    end
    bus.if_req = 0; bus.ls_req = 0; bus.if_flush = 0;
    repeat (8) @(negedge Clk);
    chk("end_idle", 32'(bus.busy), 0);

    bad = 0;
    for (int a = 0; a < 65536; a++)
      if (tb_byte(AW'(a)) !== rb(AW'(a))) bad++;
    chk("mem_final", 32'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
